// File: rtl/fpu_add_sub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPU add/sub unit among NUM_REQ requesters.
// Define FPU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no RR pointer).
module fpu_add_sub_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int FPU_LATENCY = 3,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ-1:0]            i_req_op,
    output logic                          o_fpu_valid,
    output logic [DATA_WIDTH-1:0]         o_fpu_a,
    output logic [DATA_WIDTH-1:0]         o_fpu_b,
    output logic                          o_fpu_op,
    input  logic [DATA_WIDTH-1:0]         i_fpu_result,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_busy
);

    // Handshake: requester k transfers its operands in a cycle where
    // i_req_valid[k] & o_req_ready[k]; ready is one-hot or zero and never waits on valid
    // of a different cycle, so a withdrawn request simply is not issued.
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_found;

    logic [ID_W-1:0]        issue_id;
    logic [FPU_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [FPU_LATENCY];
    logic [NUM_REQ-1:0]     tail_onehot;

`ifdef FPU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_rst_n && !grant_found && i_req_valid[i]) begin
                grant_found = 1'b1;
                grant[i]    = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    int              scan_idx;

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (i_rst_n && !grant_found && i_req_valid[ID_W'(scan_idx)]) begin
                grant_found                = 1'b1;
                grant[ID_W'(scan_idx)]     = 1'b1;
                grant_id                   = ID_W'(scan_idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (grant_found) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`endif

    assign o_req_ready = grant;
    assign tail_onehot = NUM_REQ'(1) << tag_id[FPU_LATENCY-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fpu_valid <= 1'b0;
            o_fpu_a     <= '0;
            o_fpu_b     <= '0;
            o_fpu_op    <= 1'b0;
            issue_id    <= '0;
            tag_v       <= '0;
            for (int i = 0; i < FPU_LATENCY; i++) tag_id[i] <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_fpu_valid <= grant_found;
            if (grant_found) begin
                o_fpu_a  <= i_req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                o_fpu_b  <= i_req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                o_fpu_op <= i_req_op[grant_id];
                issue_id <= grant_id;
            end
            // Tag shifts every cycle, bubbles included, so the tail lines up with the FPU output.
            tag_v[0]  <= o_fpu_valid;
            tag_id[0] <= issue_id;
            for (int i = 1; i < FPU_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            o_rsp_valid <= tag_v[FPU_LATENCY-1] ? tail_onehot : '0;
            if (tag_v[FPU_LATENCY-1]) o_rsp_data <= i_fpu_result;
        end
    end

    assign o_busy = o_fpu_valid | (|tag_v) | (|o_rsp_valid);

endmodule

// File: tb/tb_fpu_add_sub_arbiter.sv
// Directed bench for fpu_add_sub_arbiter: arbitration table, single ops, fairness,
// streaming, and reset mid-flight, with a response scoreboard and a model FPU.
module tb_fpu_add_sub_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int LAT     = 3;

    logic                  i_clk;
    logic                  i_rst_n;
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [NUM_REQ-1:0]    o_req_ready;
    logic [NUM_REQ*DW-1:0] i_req_a;
    logic [NUM_REQ*DW-1:0] i_req_b;
    logic [NUM_REQ-1:0]    i_req_op;
    logic                  o_fpu_valid;
    logic [DW-1:0]         o_fpu_a;
    logic [DW-1:0]         o_fpu_b;
    logic                  o_fpu_op;
    logic [DW-1:0]         i_fpu_result;
    logic [NUM_REQ-1:0]    o_rsp_valid;
    logic [DW-1:0]         o_rsp_data;
    logic                  o_busy;

    fpu_add_sub_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .FPU_LATENCY(LAT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
        .o_fpu_valid(o_fpu_valid), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b), .o_fpu_op(o_fpu_op),
        .i_fpu_result(i_fpu_result),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_busy(o_busy)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_rr;
        logic [3:0] exp_fix;
    } vec_t;

    vec_t        vecs [11];
    logic [35:0] exp_q [$];
    logic [35:0] mon_e;
    logic [31:0] fpu_pipe [LAT];
    int          total = 0;
    int          bad   = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
        if (a == 32'h4040_0000 && b == 32'h3F80_0000 && op)  return 32'h4000_0000;
        return a + b + {31'b0, op};
    endfunction

    // Model FPU: result appears LAT cycles after the operands are presented.
    always @(posedge i_clk) begin
        fpu_pipe[0] <= fpu_model(o_fpu_a, o_fpu_b, o_fpu_op);
        for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
    assign i_fpu_result = fpu_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_a(input int row, input int k);
        return {8'(row), 8'(k), 16'h1111};
    endfunction
    function automatic logic [31:0] mk_b(input int row, input int k);
        return {8'(k), 8'(row), 16'h2222};
    endfunction
    function automatic logic row_op(input int row, input int k);
        return ((row ^ k) & 1) != 0;
    endfunction
    function automatic logic [3:0] exp_grant(input vec_t v);
`ifdef FPU_ARB_FIXED_PRIO_EN
        return v.exp_fix;
`else
        return v.exp_rr;
`endif
    endfunction
    function automatic int onehot_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask
    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic op);
        i_req_a[k*DW +: DW] = a;
        i_req_b[k*DW +: DW] = b;
        i_req_op[k]         = op;
    endtask
    task automatic set_row(input int row);
        for (int k = 0; k < NUM_REQ; k++) set_req(k, mk_a(row, k), mk_b(row, k), row_op(row, k));
    endtask
    task automatic push_exp(input int k, input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_q.push_back({4'(1 << k), fpu_model(a, b, op)});
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_req_valid = 4'hF;
        exp_q.delete();
        repeat (2) begin
            settle();
            check("rst_ready", 64'(o_req_ready), 64'd0);
            check("rst_fpu_valid", 64'(o_fpu_valid), 64'd0);
            check("rst_fpu_a", 64'(o_fpu_a), 64'd0);
            check("rst_fpu_b", 64'(o_fpu_b), 64'd0);
            check("rst_fpu_op", 64'(o_fpu_op), 64'd0);
            check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
            check("rst_rsp_data", 64'(o_rsp_data), 64'd0);
            check("rst_busy", 64'(o_busy), 64'd0);
            step();
        end
        i_rst_n     = 1'b1;
        i_req_valid = 4'h0;
    endtask

    // Scoreboard: every response must match the oldest outstanding issue.
    always @(negedge i_clk) begin
        if (i_rst_n && o_rsp_valid != 4'b0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(o_rsp_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_owner", 64'(o_rsp_valid), 64'(mon_e[35:32]));
                check("rsp_data", 64'(o_rsp_data), 64'(mon_e[31:0]));
            end
        end
    end

    initial begin
        logic [3:0] exp;
        logic [3:0] prev_exp;
        int         prev_row;
        int         k;
        int         rsp_cnt;

        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_req_op    = '0;

        vecs[0]  = '{4'b0001, 4'b0001, 4'b0001};
        vecs[1]  = '{4'b0001, 4'b0001, 4'b0001};
        vecs[2]  = '{4'b1111, 4'b0010, 4'b0001};
        vecs[3]  = '{4'b1111, 4'b0100, 4'b0001};
        vecs[4]  = '{4'b1111, 4'b1000, 4'b0001};
        vecs[5]  = '{4'b1111, 4'b0001, 4'b0001};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b1001, 4'b1000, 4'b0001};
        vecs[8]  = '{4'b0110, 4'b0010, 4'b0010};
        vecs[9]  = '{4'b0010, 4'b0010, 4'b0010};
        vecs[10] = '{4'b1010, 4'b1000, 4'b0010};

        do_reset();

        // Arbitration table with issue-stage follow-up checks
        prev_exp = '0;
        prev_row = 0;
        for (int i = 0; i < 11; i++) begin
            set_row(i);
            i_req_valid = vecs[i].valid;
            settle();
            exp = exp_grant(vecs[i]);
            check("arb_ready", 64'(o_req_ready), 64'(exp));
            check("issue_valid", 64'(o_fpu_valid), 64'(prev_exp != 4'b0));
            if (prev_exp != 4'b0) begin
                k = onehot_idx(prev_exp);
                check("issue_a", 64'(o_fpu_a), 64'(mk_a(prev_row, k)));
                check("issue_b", 64'(o_fpu_b), 64'(mk_b(prev_row, k)));
                check("issue_op", 64'(o_fpu_op), 64'(row_op(prev_row, k)));
            end
            if (exp != 4'b0) begin
                k = onehot_idx(exp);
                push_exp(k, mk_a(i, k), mk_b(i, k), row_op(i, k));
            end
            prev_exp = exp;
            prev_row = i;
            step();
        end
        i_req_valid = '0;
        repeat (12) step();
        settle();
        check("table_drain_busy", 64'(o_busy), 64'd0);
        check("table_drain_sb", 64'(exp_q.size()), 64'd0);
        step();

        // Single add from requester 1
        set_req(1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        i_req_valid = 4'b0010;
        settle();
        check("add_ready", 64'(o_req_ready), 64'b0010);
        push_exp(1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        step();
        i_req_valid = '0;
        settle();
        check("add_fpu_valid", 64'(o_fpu_valid), 64'd1);
        check("add_fpu_a", 64'(o_fpu_a), 64'h3F80_0000);
        check("add_fpu_b", 64'(o_fpu_b), 64'h4000_0000);
        check("add_fpu_op", 64'(o_fpu_op), 64'd0);
        check("add_busy", 64'(o_busy), 64'd1);
        for (int c = 2; c <= 4; c++) begin
            step();
            settle();
            check("add_early_rsp", 64'(o_rsp_valid), 64'd0);
        end
        step();
        settle();
        check("add_rsp_valid", 64'(o_rsp_valid), 64'b0010);
        check("add_rsp_data", 64'(o_rsp_data), 64'h4040_0000);
        step();
        settle();
        check("add_rsp_clear", 64'(o_rsp_valid), 64'd0);
        check("add_idle_busy", 64'(o_busy), 64'd0);
        step();

        // Single subtract from requester 2
        set_req(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
        i_req_valid = 4'b0100;
        settle();
        check("sub_ready", 64'(o_req_ready), 64'b0100);
        push_exp(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
        step();
        i_req_valid = '0;
        settle();
        check("sub_fpu_valid", 64'(o_fpu_valid), 64'd1);
        check("sub_fpu_op", 64'(o_fpu_op), 64'd1);
        repeat (4) step();
        settle();
        check("sub_rsp_valid", 64'(o_rsp_valid), 64'b0100);
        check("sub_rsp_data", 64'(o_rsp_data), 64'h4000_0000);
        step();

        // Fairness with all requesters active
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_row(20 + c);
            i_req_valid = 4'b1111;
            settle();
`ifdef FPU_ARB_FIXED_PRIO_EN
            exp = 4'b0001;
`else
            exp = 4'(1 << (c % 4));
`endif
            check("fair_grant", 64'(o_req_ready), 64'(exp));
            k = onehot_idx(exp);
            push_exp(k, mk_a(20 + c, k), mk_b(20 + c, k), row_op(20 + c, k));
            step();
        end
        i_req_valid = '0;
        repeat (12) step();

        // Back-to-back stream from requester 3
        for (int c = 0; c < 12; c++) begin
            if (c < 6) begin
                set_req(3, 32'h4100_0000 + 32'(c), 32'h3F80_0000, 1'b0);
                i_req_valid = 4'b1000;
            end else begin
                i_req_valid = '0;
            end
            settle();
            if (c < 6) begin
                check("stream_ready", 64'(o_req_ready), 64'b1000);
                push_exp(3, 32'h4100_0000 + 32'(c), 32'h3F80_0000, 1'b0);
            end
            if (c >= 5 && c <= 10) begin
                check("stream_rsp_valid", 64'(o_rsp_valid), 64'b1000);
                check("stream_rsp_data", 64'(o_rsp_data),
                      64'(fpu_model(32'h4100_0000 + 32'(c - 5), 32'h3F80_0000, 1'b0)));
                check("stream_busy", 64'(o_busy), 64'd1);
            end
            if (c == 11) begin
                check("stream_end_rsp", 64'(o_rsp_valid), 64'd0);
                check("stream_end_busy", 64'(o_busy), 64'd0);
            end
            step();
        end

        // Reset two cycles after three issues discards them and clears the pointer
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_req(c, 32'h4200_0000 + 32'(c), 32'h4200_0000, 1'b0);
            i_req_valid = 4'(1 << c);
            settle();
            check("flight_ready", 64'(o_req_ready), 64'(1 << c));
            step();
        end
        i_req_valid = '0;
        settle();
        step();
        do_reset();
        set_req(1, 32'h4300_0000, 32'h3F80_0000, 1'b1);
        i_req_valid = 4'b1010;
        settle();
        check("post_rst_ptr", 64'(o_req_ready), 64'b0010);
        push_exp(1, 32'h4300_0000, 32'h3F80_0000, 1'b1);
        step();
        i_req_valid = '0;
        rsp_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (o_rsp_valid != 4'b0) rsp_cnt++;
            step();
        end
        check("post_rst_rsp_count", 64'(rsp_cnt), 64'd1);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
